// File: rtl/ctu_dbg_port_ser_pkg.sv
// Shared CTU debug package: FSM state encoding, beat/word widths and the
// helpers that split a captured debug word into its port beats.
package ctu_dbg_port_ser_pkg;

    localparam int BEAT_W = 20;
    localparam int WORD_W = 40;
    localparam int TS_W   = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_TS   = 2'b11
    } dbg_state_e;

    // Low half of a debug word, sent as the first data beat.
    function automatic logic [BEAT_W-1:0] word_lo(input logic [WORD_W-1:0] w);
        return w[BEAT_W-1:0];
    endfunction

    // High half of a debug word, sent as the second data beat.
    function automatic logic [BEAT_W-1:0] word_hi(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:BEAT_W];
    endfunction

endpackage

// File: rtl/ctu_dbg_port_ser_fifo.sv
// ctu_dbg_fifo: small synchronous FIFO holding captured debug words.
// A push and a pop on the same edge are allowed even when full; the
// caller is responsible for never pushing a full FIFO without a pop and
// never popping an empty one.
module ctu_dbg_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage: cleared on reset so no stale word can ever reach the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/ctu_dbg_port_ser.sv
// ctu_dbg_port_ser: captures 40-bit L2 debug words into a FIFO and
// serialises them onto a 20-bit debug port as framed beats (low half with
// sof, then high half). Words arriving while the FIFO is full and not
// being popped are dropped and counted (saturating).
// Optional build macro CTU_DBG_PORT_TS_EN: adds a free-running 20-bit
// cycle counter captured with each word and sent as a leading TS beat.
module ctu_dbg_port_ser
    import ctu_dbg_port_ser_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DROP_W = 8
) (
    input  logic              rclk,
    input  logic              reset,
    input  logic [WORD_W-1:0] l2_dbgbus_in,
    input  logic              enable_01,
    input  logic              dbg_en,
    output logic [BEAT_W-1:0] dbg_port_data,
    output logic              dbg_port_vld,
    output logic              dbg_port_sof,
    output logic [DROP_W-1:0] dbg_drop_cnt,
    output logic              dbg_fifo_empty
);

`ifdef CTU_DBG_PORT_TS_EN
    localparam int FIFO_W = WORD_W + TS_W;
`else
    localparam int FIFO_W = WORD_W;
`endif

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [FIFO_W-1:0] wdata_s;
    logic [FIFO_W-1:0] head_s;
    logic [PTR_W:0]    count_s;
    logic              capture_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;

    dbg_state_e        state_r;
    dbg_state_e        state_nxt_s;
    dbg_state_e        first_state_s;
    logic [BEAT_W-1:0] first_data_s;
    logic [BEAT_W-1:0] data_r;
    logic [BEAT_W-1:0] data_nxt_s;
    logic              vld_r;
    logic              vld_nxt_s;
    logic              sof_r;
    logic              sof_nxt_s;
    logic [DROP_W-1:0] drop_cnt_r;

    // The head leaves the FIFO as its high beat is loaded, so a full FIFO
    // can still accept a word on that same edge.
    assign capture_s = enable_01 & dbg_en;
    assign full_s    = (count_s == DEPTH_C);
    assign pop_s     = (state_r == ST_LO);
    assign push_s    = capture_s & (~full_s | pop_s);
    assign drop_s    = capture_s & full_s & ~pop_s;

`ifdef CTU_DBG_PORT_TS_EN
    logic [TS_W-1:0] ts_r;

    // Free-running cycle stamp, wraps modulo 2^20.
    always_ff @(posedge rclk) begin
        if (reset) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1'b1);
        end
    end

    assign wdata_s       = {ts_r, l2_dbgbus_in};
    assign first_state_s = ST_TS;
    assign first_data_s  = head_s[FIFO_W-1:WORD_W];
`else
    assign wdata_s       = l2_dbgbus_in;
    assign first_state_s = ST_LO;
    assign first_data_s  = word_lo(head_s[WORD_W-1:0]);
`endif

    ctu_dbg_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (rclk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (head_s),
        .count (count_s)
    );

    // Next-state and next-beat selection; every beat is loaded into the
    // output registers on the edge that enters its state.
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = {BEAT_W{1'b0}};
        vld_nxt_s   = 1'b0;
        sof_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_HI: begin
                if (count_s != {(PTR_W+1){1'b0}}) begin
                    state_nxt_s = first_state_s;
                    data_nxt_s  = first_data_s;
                    vld_nxt_s   = 1'b1;
                    sof_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef CTU_DBG_PORT_TS_EN
            ST_TS: begin
                state_nxt_s = ST_LO;
                data_nxt_s  = word_lo(head_s[WORD_W-1:0]);
                vld_nxt_s   = 1'b1;
                sof_nxt_s   = 1'b0;
            end
`endif
            ST_LO: begin
                state_nxt_s = ST_HI;
                data_nxt_s  = word_hi(head_s[WORD_W-1:0]);
                vld_nxt_s   = 1'b1;
                sof_nxt_s   = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered port outputs; reset abandons any word in flight.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            data_r  <= {BEAT_W{1'b0}};
            vld_r   <= 1'b0;
            sof_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            data_r  <= data_nxt_s;
            vld_r   <= vld_nxt_s;
            sof_r   <= sof_nxt_s;
        end
    end

    // Saturating count of words lost to a full FIFO.
    always_ff @(posedge rclk) begin
        if (reset) begin
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_W'(1'b1);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign dbg_port_data  = data_r;
    assign dbg_port_vld   = vld_r;
    assign dbg_port_sof   = sof_r;
    assign dbg_drop_cnt   = drop_cnt_r;
    assign dbg_fifo_empty = (count_s == {(PTR_W+1){1'b0}});

endmodule

// File: tb/tb_ctu_dbg_port_ser.sv
// Self-checking bench for ctu_dbg_port_ser (default two-beat build).
// A queue-based reference model tracks accepted words and the beat being
// shown; directed scenarios are followed by a randomized run.
module tb_ctu_dbg_port_ser;

    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int DROP_W = 8;

    logic        rclk;
    logic        reset;
    logic [39:0] l2_dbgbus_in;
    logic        enable_01;
    logic        dbg_en;
    logic [19:0] dbg_port_data;
    logic        dbg_port_vld;
    logic        dbg_port_sof;
    logic [7:0]  dbg_drop_cnt;
    logic        dbg_fifo_empty;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [39:0] q[$];
    int          m_phase;   // 0 idle, 1 showing low beat, 2 showing high beat
    logic [19:0] m_data;
    logic        m_vld;
    logic        m_sof;
    int          m_drop;

    ctu_dbg_port_ser #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .DROP_W (DROP_W)
    ) dut (
        .rclk           (rclk),
        .reset          (reset),
        .l2_dbgbus_in   (l2_dbgbus_in),
        .enable_01      (enable_01),
        .dbg_en         (dbg_en),
        .dbg_port_data  (dbg_port_data),
        .dbg_port_vld   (dbg_port_vld),
        .dbg_port_sof   (dbg_port_sof),
        .dbg_drop_cnt   (dbg_drop_cnt),
        .dbg_fifo_empty (dbg_fifo_empty)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model over one rising edge with the given inputs.
    task automatic model_edge(input logic rst, input logic en, input logic den, input logic [39:0] w);
        logic [39:0] head;
        bit          pop_now;
        bit          accept;
        if (rst) begin
            q.delete();
            m_phase = 0;
            m_data  = 20'h0;
            m_vld   = 1'b0;
            m_sof   = 1'b0;
            m_drop  = 0;
        end else begin
            pop_now = (m_phase == 1);
            accept  = en && den && ((q.size() < DEPTH) || pop_now);
            if (en && den && !accept && m_drop < 255) m_drop++;
            if (m_phase == 1) begin
                head    = q.pop_front();
                m_data  = head[39:20];
                m_vld   = 1'b1;
                m_sof   = 1'b0;
                m_phase = 2;
            end else if (q.size() > 0) begin
                head    = q[0];
                m_data  = head[19:0];
                m_vld   = 1'b1;
                m_sof   = 1'b1;
                m_phase = 1;
            end else begin
                m_data  = 20'h0;
                m_vld   = 1'b0;
                m_sof   = 1'b0;
                m_phase = 0;
            end
            if (accept) q.push_back(w);
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, and compare all outputs shortly after it.
    task automatic step(input logic rst, input logic en, input logic den, input logic [39:0] w);
        @(negedge rclk);
        reset        = rst;
        enable_01    = en;
        dbg_en       = den;
        l2_dbgbus_in = w;
        @(posedge rclk);
        model_edge(rst, en, den, w);
        #1;
        check_val("data",  64'(dbg_port_data),  64'(m_data));
        check_val("vld",   64'(dbg_port_vld),   64'(m_vld));
        check_val("sof",   64'(dbg_port_sof),   64'(m_sof));
        check_val("drop",  64'(dbg_drop_cnt),   64'(m_drop));
        check_val("empty", 64'(dbg_fifo_empty), 64'(q.size() == 0));
    endtask

    function automatic logic [39:0] rand_word();
        return {8'($urandom), 32'($urandom)};
    endfunction

    initial begin
        int vld_beats;
        int sof_beats;
        int run;
        int max_run;

        reset        = 1'b1;
        enable_01    = 1'b0;
        dbg_en       = 1'b0;
        l2_dbgbus_in = 40'h0;
        m_phase = 0; m_data = 20'h0; m_vld = 1'b0; m_sof = 1'b0; m_drop = 0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 40'h0);
        step(1'b1, 1'b0, 1'b0, 40'h0);
        check_val("rst_empty", 64'(dbg_fifo_empty), 64'd1);
        check_val("rst_vld",   64'(dbg_port_vld),   64'd0);

        // Single word: low beat at t+2, high at t+3, then idle
        step(1'b0, 1'b1, 1'b1, 40'hA_BCDE_1_2345);
        step(1'b0, 1'b0, 1'b1, 40'h0);
        check_val("sw_lo_data", 64'(dbg_port_data), 64'h12345);
        check_val("sw_lo_sof",  64'(dbg_port_sof),  64'd1);
        step(1'b0, 1'b0, 1'b1, 40'h0);
        check_val("sw_hi_data", 64'(dbg_port_data), 64'hABCDE);
        check_val("sw_hi_sof",  64'(dbg_port_sof),  64'd0);
        step(1'b0, 1'b0, 1'b1, 40'h0);
        check_val("sw_idle_vld", 64'(dbg_port_vld), 64'd0);
        repeat (2) step(1'b0, 1'b0, 1'b1, 40'h0);

        // Back-to-back: one word every 2 cycles streams without a gap
        vld_beats = 0; sof_beats = 0; run = 0; max_run = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, (i < 8) && (i % 2 == 0), 1'b1, rand_word());
            if (dbg_port_vld) begin
                vld_beats++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (dbg_port_sof) sof_beats++;
        end
        check_val("b2b_beats", 64'(vld_beats), 64'd8);
        check_val("b2b_run",   64'(max_run),   64'd8);
        check_val("b2b_sof",   64'(sof_beats), 64'd4);
        check_val("b2b_drop",  64'(dbg_drop_cnt), 64'd0);

        // Overflow: 12 consecutive words against DEPTH=4, then drain
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, rand_word());
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 40'h0);
        check_val("ovf_drained", 64'(dbg_fifo_empty), 64'd1);
        check_val("ovf_dropped_some", 64'(dbg_drop_cnt != 8'd0), 64'd1);

        // dbg_en gating: pulses with dbg_en low are ignored entirely
        step(1'b1, 1'b0, 1'b0, 40'h0);
        vld_beats = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'(i % 2), 1'b0, rand_word());
            if (dbg_port_vld) vld_beats++;
        end
        check_val("gate_beats", 64'(vld_beats), 64'd0);
        check_val("gate_drop",  64'(dbg_drop_cnt), 64'd0);

        // Queue 3 words, then drop dbg_en: all 3 still go out
        sof_beats = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, rand_word());
            if (dbg_port_sof) sof_beats++;
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, rand_word());
            if (dbg_port_sof) sof_beats++;
        end
        check_val("gate_drain_words", 64'(sof_beats), 64'd3);
        check_val("gate_drain_empty", 64'(dbg_fifo_empty), 64'd1);

        // Reset during the low beat: no high beat follows
        step(1'b0, 1'b1, 1'b1, 40'h5_5555_A_AAAA);
        step(1'b0, 1'b0, 1'b1, 40'h0);
        check_val("mid_lo_vld", 64'(dbg_port_vld), 64'd1);
        step(1'b1, 1'b0, 1'b1, 40'h0);
        check_val("mid_rst_vld",   64'(dbg_port_vld),   64'd0);
        check_val("mid_rst_data",  64'(dbg_port_data),  64'd0);
        check_val("mid_rst_empty", 64'(dbg_fifo_empty), 64'd1);
        step(1'b0, 1'b0, 1'b1, 40'h0);
        check_val("mid_no_hi", 64'(dbg_port_vld), 64'd0);

        // Saturation: continuous input drops roughly every other word
        for (int i = 0; i < 700; i++) step(1'b0, 1'b1, 1'b1, rand_word());
        check_val("sat_cnt", 64'(dbg_drop_cnt), 64'hFF);
        step(1'b1, 1'b0, 1'b0, 40'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 85),
                 rand_word());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
